// File: rtl/core_tile_sched_if.sv
`default_nettype none
// ============================================================================
// core_tile_sched_if : DMA burst handshake and pixel-core start/done pair
// Revision: 1.0
// ============================================================================
interface core_tile_sched_if #(
    parameter int ADDR_W = 32
);
    logic              O_DMA_REQ;
    logic              O_DMA_WRITE;
    logic [ADDR_W-1:0] O_DMA_ADDR;
    logic              O_CORE_START;
    logic              I_DMA_ACK;
    logic              I_DMA_DONE;
    logic              I_CORE_DONE;

    modport master (
        output O_DMA_REQ,
        output O_DMA_WRITE,
        output O_DMA_ADDR,
        output O_CORE_START,
        input  I_DMA_ACK,
        input  I_DMA_DONE,
        input  I_CORE_DONE
    );

    modport slave (
        input  O_DMA_REQ,
        input  O_DMA_WRITE,
        input  O_DMA_ADDR,
        input  O_CORE_START,
        output I_DMA_ACK,
        output I_DMA_DONE,
        output I_CORE_DONE
    );
endinterface
`default_nettype wire

// File: rtl/core_tile_sched.sv
`default_nettype none
// ============================================================================
// core_tile_sched : walks the image in 8x8 tiles, reading rows, running the
//                   pixel core and writing rows to the rotated tile position
// Revision: 1.0
// ============================================================================
module core_tile_sched #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic                I_HCLK,
    input  logic                I_HRESET,
    input  logic                I_START,
    input  logic                I_DIRECTION,
    input  logic [1:0]          I_DEGREES,
    input  logic [DIM_W-1:0]    I_WIDTH,
    input  logic [DIM_W-1:0]    I_HEIGHT,
    input  logic [ADDR_W-1:0]   I_SRC_BASE,
    input  logic [ADDR_W-1:0]   I_DST_BASE,
    core_tile_sched_if.master   bus,
    output logic                O_BUSY,
    output logic                O_DONE,
    output logic                O_ERR
);
    localparam int TW = DIM_W - 3;

    localparam logic [3:0] C_IDLE    = 4'd0;
    localparam logic [3:0] C_CALC    = 4'd1;
    localparam logic [3:0] C_RD_REQ  = 4'd2;
    localparam logic [3:0] C_RD_WAIT = 4'd3;
    localparam logic [3:0] C_CORE    = 4'd4;
    localparam logic [3:0] C_WR_REQ  = 4'd5;
    localparam logic [3:0] C_WR_WAIT = 4'd6;
    localparam logic [3:0] C_NEXT    = 4'd7;
    localparam logic [3:0] C_DONE    = 4'd8;

    localparam logic [1:0] C_ROT_0   = 2'd0;
    localparam logic [1:0] C_ROT_180 = 2'd1;
    localparam logic [1:0] C_ROT_R   = 2'd2;
    localparam logic [1:0] C_ROT_L   = 2'd3;

    logic [3:0]        state_q, state_d;
    logic [1:0]        rot_q;
    logic [DIM_W-1:0]  width_q, height_q;
    logic [ADDR_W-1:0] src_base_q, dst_base_q;
    logic [ADDR_W-1:0] src_addr_q, dst_addr_q;
    logic [ADDR_W-1:0] src_pitch_q, dst_pitch_q;
    logic [TW-1:0]     tx_q, ty_q;
    logic [2:0]        row_q;
    logic              err_q;
    logic              core_seen_q;

    logic              w_dims_ok;
    logic [1:0]        w_rot;
    logic [TW-1:0]     w_tx_max, w_ty_max;
    logic [TW-1:0]     w_otx, w_oty;
    logic [DIM_W-1:0]  w_wo;
    logic              w_last_row, w_last_tile;
    logic              w_rd_beat, w_wr_beat;
    logic [ADDR_W-1:0] w_src_pix, w_dst_pix;

    function automatic logic [ADDR_W-1:0] times3(input logic [ADDR_W-1:0] v);
        return (v << 1) + v;
    endfunction

    assign w_dims_ok = (I_WIDTH != '0) && (I_HEIGHT != '0) &&
                       (I_WIDTH[2:0] == 3'd0) && (I_HEIGHT[2:0] == 3'd0);

    // CCW90 and CW270 are the same turn, as are CW90 and CCW270.
    always_comb begin
        w_rot = C_ROT_0;
        case (I_DEGREES)
            2'd1:    w_rot = I_DIRECTION ? C_ROT_L : C_ROT_R;
            2'd2:    w_rot = C_ROT_180;
            2'd3:    w_rot = I_DIRECTION ? C_ROT_R : C_ROT_L;
            default: w_rot = C_ROT_0;
        endcase
    end

    assign w_tx_max    = width_q[DIM_W-1:3]  - TW'(1);
    assign w_ty_max    = height_q[DIM_W-1:3] - TW'(1);
    assign w_last_row  = (row_q == 3'd7);
    assign w_last_tile = (tx_q == w_tx_max) && (ty_q == w_ty_max);

    // A DONE arriving together with the ACK completes the burst immediately.
    assign w_rd_beat = bus.I_DMA_DONE &&
                       ((state_q == C_RD_WAIT) || ((state_q == C_RD_REQ) && bus.I_DMA_ACK));
    assign w_wr_beat = bus.I_DMA_DONE &&
                       ((state_q == C_WR_WAIT) || ((state_q == C_WR_REQ) && bus.I_DMA_ACK));

    always_comb begin
        w_otx = tx_q;
        w_oty = ty_q;
        w_wo  = width_q;
        case (rot_q)
            C_ROT_180: begin
                w_otx = w_tx_max - tx_q;
                w_oty = w_ty_max - ty_q;
            end
            C_ROT_R: begin
                w_otx = w_ty_max - ty_q;
                w_oty = tx_q;
                w_wo  = height_q;
            end
            C_ROT_L: begin
                w_otx = ty_q;
                w_oty = w_tx_max - tx_q;
                w_wo  = height_q;
            end
            default: ;
        endcase
    end

    assign w_src_pix = ADDR_W'({ty_q, 3'b000}) * ADDR_W'(width_q) + ADDR_W'({tx_q, 3'b000});
    assign w_dst_pix = ADDR_W'({w_oty, 3'b000}) * ADDR_W'(w_wo) + ADDR_W'({w_otx, 3'b000});

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:    if (I_START && w_dims_ok) state_d = C_CALC;
            C_CALC:    state_d = C_RD_REQ;
            C_RD_REQ: begin
                if (w_rd_beat)          state_d = w_last_row ? C_CORE : C_RD_REQ;
                else if (bus.I_DMA_ACK) state_d = C_RD_WAIT;
            end
            C_RD_WAIT: if (w_rd_beat) state_d = w_last_row ? C_CORE : C_RD_REQ;
            C_CORE:    if (bus.I_CORE_DONE) state_d = C_WR_REQ;
            C_WR_REQ: begin
                if (w_wr_beat)          state_d = w_last_row ? C_NEXT : C_WR_REQ;
                else if (bus.I_DMA_ACK) state_d = C_WR_WAIT;
            end
            C_WR_WAIT: if (w_wr_beat) state_d = w_last_row ? C_NEXT : C_WR_REQ;
            C_NEXT:    state_d = w_last_tile ? C_DONE : C_CALC;
            C_DONE:    state_d = C_IDLE;
            default:   state_d = C_IDLE;
        endcase
    end

    always_comb begin
        bus.O_DMA_REQ    = (state_q == C_RD_REQ) || (state_q == C_WR_REQ);
        bus.O_DMA_WRITE  = (state_q == C_WR_REQ);
        bus.O_DMA_ADDR   = '0;
        if (state_q == C_RD_REQ) bus.O_DMA_ADDR = src_addr_q;
        if (state_q == C_WR_REQ) bus.O_DMA_ADDR = dst_addr_q;
        bus.O_CORE_START = (state_q == C_CORE) && !core_seen_q;
        O_BUSY           = (state_q != C_IDLE);
        O_DONE           = (state_q == C_DONE);
        O_ERR            = err_q;
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            rot_q       <= C_ROT_0;
            width_q     <= '0;
            height_q    <= '0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
            src_pitch_q <= '0;
            dst_pitch_q <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            core_seen_q <= 1'b0;
        end else begin
            err_q       <= (state_q == C_IDLE) && I_START && !w_dims_ok;
            core_seen_q <= (state_q == C_CORE);
            case (state_q)
                C_IDLE: begin
                    if (I_START) begin
                        rot_q      <= w_rot;
                        width_q    <= I_WIDTH;
                        height_q   <= I_HEIGHT;
                        src_base_q <= I_SRC_BASE;
                        dst_base_q <= I_DST_BASE;
                        tx_q       <= '0;
                        ty_q       <= '0;
                        row_q      <= '0;
                    end
                end
                C_CALC: begin
                    src_addr_q  <= src_base_q + times3(w_src_pix);
                    dst_addr_q  <= dst_base_q + times3(w_dst_pix);
                    src_pitch_q <= times3(ADDR_W'(width_q));
                    dst_pitch_q <= times3(ADDR_W'(w_wo));
                end
                // The 3-bit row counter wraps 7 -> 0 on the last burst of a tile.
                C_RD_REQ, C_RD_WAIT: begin
                    if (w_rd_beat) begin
                        row_q      <= row_q + 3'd1;
                        src_addr_q <= src_addr_q + src_pitch_q;
                    end
                end
                C_WR_REQ, C_WR_WAIT: begin
                    if (w_wr_beat) begin
                        row_q      <= row_q + 3'd1;
                        dst_addr_q <= dst_addr_q + dst_pitch_q;
                    end
                end
                C_NEXT: begin
                    if (tx_q == w_tx_max) begin
                        tx_q <= '0;
                        ty_q <= (ty_q == w_ty_max) ? '0 : ty_q + TW'(1);
                    end else begin
                        tx_q <= tx_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_core_tile_sched.sv
`default_nettype none
// Testbench for core_tile_sched: expected DMA bursts are queued at start and
// popped as the DUT issues requests, with a DMA/core responder in the loop.
module tb_core_tile_sched;
    localparam int ADDR_W = 32;
    localparam int DIM_W  = 16;
    localparam int BUDGET = 5000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              dir;
    logic [1:0]        deg;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic              busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W:0] exp_q [$];

    always #5 clk = ~clk;

    core_tile_sched_if #(.ADDR_W(ADDR_W)) bus ();

    core_tile_sched #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .I_HCLK      (clk),
        .I_HRESET    (rst),
        .I_START     (start),
        .I_DIRECTION (dir),
        .I_DEGREES   (deg),
        .I_WIDTH     (width),
        .I_HEIGHT    (height),
        .I_SRC_BASE  (src_base),
        .I_DST_BASE  (dst_base),
        .bus         (bus),
        .O_BUSY      (busy),
        .O_DONE      (done),
        .O_ERR       (err)
    );

    task automatic push_expected(input int w, input int h, input bit d, input int dg,
                                 input logic [31:0] src, input logic [31:0] dst);
        int  ntx = w / 8;
        int  nty = h / 8;
        int  otx, oty, wo;
        bit  r90r, r90l;
        r90r = (dg == 1 && !d) || (dg == 3 && d);
        r90l = (dg == 1 && d) || (dg == 3 && !d);
        for (int ty = 0; ty < nty; ty++) begin
            for (int tx = 0; tx < ntx; tx++) begin
                for (int r = 0; r < 8; r++)
                    exp_q.push_back({1'b0, src + 32'(((8 * ty + r) * w + 8 * tx) * 3)});
                if (r90r) begin
                    otx = nty - 1 - ty; oty = tx; wo = h;
                end else if (r90l) begin
                    otx = ty; oty = ntx - 1 - tx; wo = h;
                end else if (dg == 2) begin
                    otx = ntx - 1 - tx; oty = nty - 1 - ty; wo = w;
                end else begin
                    otx = tx; oty = ty; wo = w;
                end
                for (int r = 0; r < 8; r++)
                    exp_q.push_back({1'b1, dst + 32'(((8 * oty + r) * wo + 8 * otx) * 3)});
            end
        end
    endtask

    // Starts one image and acts as DMA and pixel core until O_DONE (or abort).
    task automatic run_image(input string tag, input int w, input int h, input bit d,
                             input int dg, input int ack_dly, input bit same,
                             input bit stress, input int abort_wr);
        logic [ADDR_W:0] got, expv, held;
        int cyc, wait_n, pend_done, pend_core, nwr, wr_done, rd_in_tile;
        int ntiles, total_wr, core_cnt, done_cnt, rd8_cyc, wr_exp_cyc, last_cyc;
        bit in_req, fin, first_req, check_drop, abort_pend, expect_wr, burst_done;
        ntiles = (w / 8) * (h / 8);
        total_wr = ntiles * 8;
        wait_n = 0; pend_done = 0; pend_core = 0; nwr = 0; wr_done = 0; rd_in_tile = 0;
        core_cnt = 0; done_cnt = 0; rd8_cyc = -10; wr_exp_cyc = -10; last_cyc = -10;
        in_req = 0; fin = 0; first_req = 1; check_drop = 0; abort_pend = 0;
        expect_wr = 0; burst_done = 0; held = '0;
        push_expected(w, h, d, dg, 32'h1000, 32'h2000);

        @(posedge clk); #1;
        start = 1'b1; dir = d; deg = 2'(dg);
        width = 16'(w); height = 16'(h);
        src_base = 32'h1000; dst_base = 32'h2000;
        @(posedge clk); #1;
        // Scramble the configuration: it must have been latched at start.
        start = 1'b0; dir = ~d; deg = 2'(dg + 1);
        width = 16'd8; height = 16'd8;
        src_base = 32'hDEAD0000; dst_base = 32'hBEEF0000;
        checks++;
        if (busy !== 1'b1 || bus.O_DMA_REQ !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_edge1: busy=%b req=%b, need busy=1 req=0", tag, busy, bus.O_DMA_REQ);
        end
        cyc = 1;

        while (!fin && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            bus.I_DMA_ACK = 1'b0; bus.I_DMA_DONE = 1'b0; bus.I_CORE_DONE = 1'b0; start = 1'b0;

            if (abort_pend) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                checks++;
                if ({bus.O_DMA_REQ, bus.O_DMA_WRITE, bus.O_CORE_START, busy, done, err} !== 6'b0 ||
                    bus.O_DMA_ADDR !== '0) begin
                    errors++;
                    $display("FAIL %s reset_outputs: req=%b wr=%b addr=%h cs=%b busy=%b done=%b err=%b, need all 0",
                             tag, bus.O_DMA_REQ, bus.O_DMA_WRITE, bus.O_DMA_ADDR, bus.O_CORE_START, busy, done, err);
                end
                exp_q.delete();
                return;
            end

            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s err_while_busy: err=%b, need 0", tag, err);
            end
            if (check_drop) begin
                check_drop = 0;
                checks++;
                if (bus.O_DMA_REQ !== 1'b0) begin
                    errors++;
                    $display("FAIL %s req_drop: req=%b, need 0", tag, bus.O_DMA_REQ);
                end
            end

            if (bus.O_CORE_START === 1'b1) begin
                core_cnt++;
                checks++;
                if (cyc != rd8_cyc + 1) begin
                    errors++;
                    $display("FAIL %s core_start_lat: cycle %0d, need %0d", tag, cyc, rd8_cyc + 1);
                end
                pend_core = 3;
                if (stress) begin
                    bus.I_DMA_DONE = 1'b1; bus.I_DMA_ACK = 1'b1; start = 1'b1;
                end
            end else if (pend_core > 0) begin
                checks++;
                if (bus.O_DMA_REQ !== 1'b0 || bus.O_CORE_START !== 1'b0) begin
                    errors++;
                    $display("FAIL %s core_wait: req=%b core_start=%b, need 0 0", tag, bus.O_DMA_REQ, bus.O_CORE_START);
                end
                pend_core--;
                if (pend_core == 0) begin
                    bus.I_CORE_DONE = 1'b1;
                    wr_exp_cyc = cyc + 1;
                    expect_wr = 1;
                end
            end

            if (pend_done > 0) begin
                pend_done--;
                if (pend_done == 0) begin
                    bus.I_DMA_DONE = 1'b1;
                    burst_done = 1;
                end
            end

            if (bus.O_DMA_REQ === 1'b1) begin
                got = {bus.O_DMA_WRITE, bus.O_DMA_ADDR};
                if (!in_req) begin
                    in_req = 1; wait_n = 0; held = got;
                    if (first_req) begin
                        first_req = 0;
                        checks++;
                        if (cyc != 2) begin
                            errors++;
                            $display("FAIL %s first_req_lat: cycle %0d, need 2", tag, cyc);
                        end
                    end
                    if (expect_wr) begin
                        expect_wr = 0;
                        checks++;
                        if (cyc != wr_exp_cyc) begin
                            errors++;
                            $display("FAIL %s wr_req_lat: cycle %0d, need %0d", tag, cyc, wr_exp_cyc);
                        end
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s burst: got %h, need no further burst", tag, got);
                    end else begin
                        expv = exp_q.pop_front();
                        if (got !== expv) begin
                            errors++;
                            $display("FAIL %s burst: got wr/addr %h, need %h", tag, got, expv);
                        end
                    end
                end else begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL %s req_hold: got %h, need %h", tag, got, held);
                    end
                end
                if (wait_n == ack_dly) begin
                    bus.I_DMA_ACK = 1'b1;
                    in_req = 0;
                    if (same) begin
                        bus.I_DMA_DONE = 1'b1;
                        burst_done = 1;
                    end else begin
                        pend_done = 2;
                        check_drop = 1;
                    end
                    if (held[ADDR_W]) begin
                        nwr++;
                        if (nwr == abort_wr) abort_pend = 1;
                    end
                end else begin
                    wait_n++;
                end
            end

            if (burst_done) begin
                burst_done = 0;
                if (held[ADDR_W]) begin
                    wr_done++;
                    if (wr_done == total_wr) last_cyc = cyc;
                end else begin
                    rd_in_tile++;
                    if (rd_in_tile == 8) begin
                        rd_in_tile = 0;
                        rd8_cyc = cyc;
                    end
                end
            end

            if (done === 1'b1) begin
                done_cnt++;
                fin = 1;
                checks++;
                if (cyc != last_cyc + 2 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done_timing: cycle %0d busy=%b, need cycle %0d busy=1", tag, cyc, busy, last_cyc + 2);
                end
            end
        end

        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: no O_DONE within %0d cycles", tag, BUDGET);
        end
        checks++;
        if (exp_q.size() != 0 || core_cnt != ntiles || done_cnt != 1) begin
            errors++;
            $display("FAIL %s totals: left=%0d core_starts=%0d dones=%0d, need 0 %0d 1",
                     tag, exp_q.size(), core_cnt, done_cnt, ntiles);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b done=%b, need 0 0", tag, busy, done);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1; width = 16'd8; height = 16'd8;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.O_DMA_REQ, bus.O_DMA_WRITE, bus.O_CORE_START, busy, done, err} !== 6'b0 ||
            bus.O_DMA_ADDR !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%b wr=%b addr=%h cs=%b busy=%b done=%b err=%b, need all 0",
                     bus.O_DMA_REQ, bus.O_DMA_WRITE, bus.O_DMA_ADDR, bus.O_CORE_START, busy, done, err);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b, need 0", busy);
        end
    endtask

    task automatic test_basic();
        run_image("basic_0deg", 8, 8, 1'b0, 0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_rot90();
        run_image("cw90", 16, 8, 1'b0, 1, 0, 1'b0, 1'b0, -1);
        run_image("ccw90", 16, 8, 1'b1, 1, 0, 1'b0, 1'b0, -1);
        run_image("cw270", 8, 16, 1'b0, 3, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reject();
        int wv [2] = '{12, 8};
        int hv [2] = '{8, 0};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            width = 16'(wv[i]); height = 16'(hv[i]); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || bus.O_DMA_REQ !== 1'b0) begin
                errors++;
                $display("FAIL reject_err %0dx%0d: err=%b busy=%b req=%b, need 1 0 0", wv[i], hv[i], err, busy, bus.O_DMA_REQ);
            end
            repeat (4) begin
                @(posedge clk); #1;
                checks++;
                if (err !== 1'b0 || busy !== 1'b0 || bus.O_DMA_REQ !== 1'b0) begin
                    errors++;
                    $display("FAIL reject_quiet %0dx%0d: err=%b busy=%b req=%b, need 0 0 0", wv[i], hv[i], err, busy, bus.O_DMA_REQ);
                end
            end
        end
    endtask

    task automatic test_handshake_stress();
        run_image("slow_ack", 16, 8, 1'b0, 1, 5, 1'b0, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        run_image("same_cycle_180", 16, 16, 1'b1, 2, 0, 1'b1, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        run_image("abort_tile3", 16, 16, 1'b0, 0, 0, 1'b0, 1'b0, 25);
        run_image("restart", 16, 16, 1'b0, 0, 0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; deg = 2'd0;
        width = '0; height = '0; src_base = '0; dst_base = '0;
        bus.I_DMA_ACK = 1'b0; bus.I_DMA_DONE = 1'b0; bus.I_CORE_DONE = 1'b0;
        test_reset();
        test_basic();
        test_rot90();
        test_reject();
        test_handshake_stress();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_tile_sched.md
# core_tile_sched

Tile scheduler for the rotation engine. It walks a source image of I_WIDTH x I_HEIGHT RGB888 pixels as 8x8 tiles in raster order. For each tile it:
- issues eight 24-byte row reads to the DMA,
- starts the pixel core, which generates the rotated in-tile addressing, and waits for it,
- issues eight 24-byte row writes to the tile's rotated position in the destination image.

It sits between the register block (configuration and start) and the DMA master / core_pixel pair.

## Interface
- ADDR_W, 32, byte address width
- DIM_W, 16, width of the dimension inputs

- I_HCLK  in  1  clock, all state changes on the rising edge
- I_HRESET  in  1  synchronous, active-high reset
- I_START  in  1  one-cycle start pulse, sampled only in IDLE
- I_DIRECTION  in  1  1 = counter-clockwise, 0 = clockwise
- I_DEGREES  in  2  0/1/2/3 = 0/90/180/270 degrees
- I_WIDTH, I_HEIGHT  in  DIM_W  source size in pixels
- I_SRC_BASE, I_DST_BASE  in  ADDR_W  byte base addresses
- I_DMA_ACK  in  1  DMA has accepted the current request
- I_DMA_DONE  in  1  one-cycle pulse, current burst complete
- I_CORE_DONE  in  1  one-cycle pulse, pixel core finished the tile
- O_DMA_REQ  out  1  burst request
- O_DMA_WRITE  out  1  1 = write burst, 0 = read burst
- O_DMA_ADDR  out  ADDR_W  burst start byte address; every burst is 24 bytes (6 words)
- O_CORE_START  out  1  one-cycle start pulse to the pixel core
- O_BUSY  out  1  high from CALC through DONE inclusive
- O_DONE  out  1  one-cycle pulse, whole image finished
- O_ERR  out  1  one-cycle pulse, start rejected because of the dimensions

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- At I_START, the block latches I_DIRECTION, I_DEGREES, I_WIDTH, I_HEIGHT, I_SRC_BASE and I_DST_BASE. Later changes to these inputs are ignored until the next start.
- Rejection: if W or H is 0, or either is not a multiple of 8, the block pulses O_ERR, stays in IDLE and leaves O_BUSY low.
- Tile counts: TX = W/8, TY = H/8. Tiles are visited in order tx fastest, then ty. Row index r runs 0..7.
- Effective rotation: CCW90 = CW270 (R90L), CW90 = CCW270 (R90R). 0 and 180 degrees are direction-independent.
- Output tile position (otx, oty) and output width Wo:
  - 0°: (tx, ty), Wo = W
  - 180°: (TX-1-tx, TY-1-ty), Wo = W
  - R90R: (TY-1-ty, tx), Wo = H
  - R90L: (ty, TX-1-tx), Wo = H
- Source row address: SRC + ((8*ty + r)*W + 8*tx)*3.
- Destination row address: DST + ((8*oty + r)*Wo + 8*otx)*3.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W. The row pitch (3*W or 3*Wo) is computed in CALC; successive rows add the pitch.
- States:
  - IDLE: on a valid start → CALC.
  - CALC: compute the tile base addresses → RD_REQ.
  - RD_REQ: O_DMA_REQ=1, O_DMA_WRITE=0; stay until I_DMA_ACK → RD_WAIT.
  - RD_WAIT: on I_DMA_DONE, if r<7 then r++ → RD_REQ; otherwise r=0 → CORE.
  - CORE: O_CORE_START pulses in the first cycle only; on I_CORE_DONE → WR_REQ.
  - WR_REQ: as RD_REQ, with O_DMA_WRITE=1 and destination addresses.
  - WR_WAIT: as RD_WAIT; after row 7 → NEXT.
  - NEXT: advance (tx, ty); if this was the last tile → DONE, otherwise → CALC.
  - DONE: O_DONE=1 for one cycle → IDLE.
- Request handshake: O_DMA_REQ, O_DMA_WRITE and O_DMA_ADDR are held stable while in REQ. REQ drops in the cycle after ACK is sampled.
- Simultaneous events:
  - I_DMA_DONE in the same cycle as ACK counts as completion of that burst (REQ → next row/state directly).
  - I_DMA_DONE, I_DMA_ACK and I_CORE_DONE in any other state are ignored.
  - I_START while busy is ignored.
- I_HRESET mid-operation: the block returns to IDLE next edge with all outputs 0. No DONE or ERR pulse is generated.

## Timing
- I_START sampled at edge 0:
  - O_BUSY=1 and state CALC from edge 1.
  - First O_DMA_REQ=1 from edge 2.
  - O_ERR, if the start is rejected, is high at edge 1 for one cycle.
- ACK sampled at edge n: REQ is low from edge n+1. The next REQ is no earlier than one cycle after DONE.
- I_DMA_DONE on the eighth read burst: O_CORE_START is high in the next cycle.
- I_CORE_DONE: first write REQ in the next cycle.
- After the final write DONE: NEXT for 1 cycle, then DONE for 1 cycle (O_DONE=1, O_BUSY=1), then IDLE with O_BUSY=0.
- Minimum per-tile overhead beyond DMA and core latency is 19 cycles.

## Test plan
- W=8, H=8, 0°, SRC=0x1000, DST=0x2000, DMA acks and dones immediately:
  - reads at 0x1000, 0x1018, …, 0x10A8;
  - one O_CORE_START;
  - writes at 0x2000 … 0x20A8;
  - one O_DONE.
- W=16, H=8, CW90 (dir=0, deg=1):
  - tile (1,0) read rows at 0x1018, 0x1048, … (pitch 0x30);
  - written to 0x20C0, 0x20D8, … (Wo=8, oty=1, pitch 0x18).
- Same image, CCW90 (dir=1, deg=1):
  - tile (0,0) written to 0x20C0;
  - tile (1,0) written to 0x2000.
- W=12 or H=0 with I_START: O_ERR pulse at edge 1, no REQ, O_BUSY stays 0.
- Handshake stress:
  - ACK delayed 5 cycles: REQ and ADDR are held stable;
  - ACK and DONE asserted in the same cycle: the row advances;
  - a spurious DONE in CORE is ignored;
  - I_START while busy is ignored.
- I_HRESET asserted during WR_WAIT of tile 3: all outputs are 0 at the next edge; a new start restarts from tile 0 with row 0.
